// File: rtl/rsa_const_gen.sv
// Montgomery constant generator: Const = R^2 mod M with R = 2^(WIDTH+2),
// computed serially by repeated doubling with conditional subtraction.
module rsa_const_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Const,
  output logic             busy,
  output logic             done,
  output logic             err
);
  // state  | meaning
  // S_IDLE | waiting for start; Const/err hold the last outcome
  // S_CALC | one doubling step of r per enabled edge, 2K steps total

  localparam int K     = WIDTH + 2;
  localparam int NITER = 2 * K;
  localparam int CW    = $clog2(NITER);
  localparam logic [CW-1:0] LAST = CW'(NITER - 1);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_const;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_next;
  logic             w_m_valid;

  // r < M keeps 2r below 2M, so the reduced value always fits in WIDTH bits
  // and the subtraction can be done modulo 2^WIDTH.
  assign w_t       = {r_r, 1'b0};
  assign w_shift   = {r_r[WIDTH-2:0], 1'b0};
  assign w_ge      = (w_t >= {1'b0, r_m});
  assign w_next    = w_ge ? (w_shift - r_m) : w_shift;
  assign w_m_valid = M[0] && (M != WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rstb) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_const <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (w_m_valid) begin
              r_m     <= M;
              r_r     <= WIDTH'(1);
              r_cnt   <= '0;
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end else begin
              r_const <= '0;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (clear) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_r   <= w_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_const <= w_next;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Const = r_const;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_rsa_const_gen.sv
// Self-checking bench for rsa_const_gen (WIDTH=8): expected constants are
// queued when a valid start is driven and popped when done is observed.
module tb_rsa_const_gen;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rstb, ena, clear, start;
  logic [WIDTH-1:0] M;
  logic [WIDTH-1:0] Const;
  logic             busy, done, err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q[$];

  rsa_const_gen #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(clear), .start(start),
    .M(M), .Const(Const), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] m);
    longint unsigned p;
    p = 64'd1 << (2 * (WIDTH + 2));
    return WIDTH'(p % longint'(m));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int edges);
    int iters;
    iters = 0;
    edges = 0;
    while (done !== 1'b1 && iters < 200) begin
      if (ena) edges++;
      step();
      iters++;
    end
  endtask

  task automatic test_reset();
    int n_done;
    rstb = 1'b1; ena = 1'b1; clear = 1'b0; start = 1'b0; M = '0;
    step(); step();
    rstb = 1'b0;
    step();
    n_checks++; if ({Const, busy, done, err} !== '0) $display("FAIL reset_init: got Const=%0d busy=%b done=%b err=%b want 0/0/0/0", Const, busy, done, err); else n_pass++;
    M = 8'd251; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    rstb = 1'b1;
    step();
    rstb = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_mid_calc: got busy=%b done=%b want 0/0", busy, done); else n_pass++;
    n_checks++; if (Const !== '0 || err !== 1'b0) $display("FAIL reset_outputs: got Const=%0d err=%b want 0/0", Const, err); else n_pass++;
    n_done = 0;
    repeat (30) begin
      step();
      if (done === 1'b1) n_done++;
    end
    n_checks++; if (n_done !== 0) $display("FAIL reset_no_done: got %0d done pulses want 0", n_done); else n_pass++;
  endtask

  task automatic test_basic();
    int busy_cnt, iters;
    logic [WIDTH-1:0] e;
    M = 8'd251; exp_q.push_back(model(8'd251)); start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = 0; iters = 0;
    while (done !== 1'b1 && iters < 100) begin
      if (busy === 1'b1) busy_cnt++;
      step();
      iters++;
    end
    n_checks++; if (busy_cnt !== 20 || iters !== 20) $display("FAIL basic_latency: got busy=%0d latency=%0d want 20/20", busy_cnt, iters); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++; if (Const !== e || busy !== 1'b0) $display("FAIL basic_const: got %0d busy=%b want %0d busy=0", Const, busy, e); else n_pass++;
    step();
    n_checks++; if (done !== 1'b0 || Const !== e) $display("FAIL basic_single_pulse: got done=%b Const=%0d want 0/%0d", done, Const, e); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ms[3];
    logic [WIDTH-1:0] e;
    int edges;
    ms[0] = 8'd187; ms[1] = 8'd255; ms[2] = 8'd3;
    M = ms[0]; exp_q.push_back(model(ms[0])); start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_done(edges);
      n_checks++; if (done !== 1'b1 || edges !== 20) $display("FAIL b2b_latency[%0d]: got done=%b edges=%0d want 1/20", i, done, edges); else n_pass++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++; if (Const !== e) $display("FAIL b2b_const[%0d]: got %0d want %0d", i, Const, e); else n_pass++;
      if (i < 2) begin
        M = ms[i+1]; exp_q.push_back(model(ms[i+1])); start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_accept[%0d]: got done=%b busy=%b want 0/1", i, done, busy); else n_pass++;
      end else begin
        step();
        n_checks++; if (done !== 1'b0) $display("FAIL b2b_end: got done=%b want 0", done); else n_pass++;
      end
    end
  endtask

  task automatic test_invalid();
    logic [WIDTH-1:0] ms[3];
    logic [WIDTH-1:0] e;
    int edges, busy_seen;
    ms[0] = 8'h40; ms[1] = 8'd1; ms[2] = 8'd0;
    busy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      M = ms[i]; start = 1'b1;
      step();
      start = 1'b0;
      if (busy === 1'b1) busy_seen++;
      n_checks++; if (err !== 1'b1 || done !== 1'b1 || Const !== '0) $display("FAIL invalid[%0d]: got err=%b done=%b Const=%0d want 1/1/0", i, err, done, Const); else n_pass++;
      step();
      if (busy === 1'b1) busy_seen++;
      n_checks++; if (done !== 1'b0 || err !== 1'b1) $display("FAIL invalid_hold[%0d]: got done=%b err=%b want 0/1", i, done, err); else n_pass++;
    end
    n_checks++; if (busy_seen !== 0) $display("FAIL invalid_busy: got %0d busy cycles want 0", busy_seen); else n_pass++;
    M = 8'd3; exp_q.push_back(model(8'd3)); start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL invalid_recover: got err=%b busy=%b want 0/1", err, busy); else n_pass++;
    wait_done(edges);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++; if (done !== 1'b1 || Const !== e || err !== 1'b0) $display("FAIL invalid_recover_const: got done=%b Const=%0d err=%b want 1/%0d/0", done, Const, err, e); else n_pass++;
    step();
  endtask

  task automatic test_ena();
    int edges, iters, frozen_bad;
    logic p_busy, p_done;
    logic [WIDTH-1:0] p_const, e;
    M = 8'd251; exp_q.push_back(model(8'd251)); ena = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    edges = 0; iters = 0; frozen_bad = 0;
    while (done !== 1'b1 && iters < 200) begin
      ena = iters[0];
      if ($urandom_range(0, 1) == 1) M = 8'($urandom);
      p_busy = busy; p_done = done; p_const = Const;
      if (ena) edges++;
      step();
      if (!ena && (busy !== p_busy || done !== p_done || Const !== p_const)) frozen_bad++;
      iters++;
    end
    n_checks++; if (frozen_bad !== 0) $display("FAIL ena_frozen: got %0d changes on disabled edges want 0", frozen_bad); else n_pass++;
    n_checks++; if (done !== 1'b1 || edges !== 20) $display("FAIL ena_latency: got done=%b edges=%0d want 1/20", done, edges); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++; if (Const !== e) $display("FAIL ena_const: got %0d want %0d", Const, e); else n_pass++;
    ena = 1'b0;
    step();
    n_checks++; if (done !== 1'b1) $display("FAIL ena_done_stretch: got done=%b want 1", done); else n_pass++;
    ena = 1'b1;
    step();
    n_checks++; if (done !== 1'b0) $display("FAIL ena_done_drop: got done=%b want 0", done); else n_pass++;
  endtask

  task automatic test_clear();
    int n_done, edges;
    logic [WIDTH-1:0] e;
    // Const is 2^20 mod 251 from the previous run.
    M = 8'd187; start = 1'b1;
    step();
    M = 8'd5;
    repeat (6) step();
    clear = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL clear_abort: got busy=%b done=%b want 0/0", busy, done); else n_pass++;
    n_checks++; if (Const !== model(8'd251) || err !== 1'b0) $display("FAIL clear_hold: got Const=%0d err=%b want %0d/0", Const, err, model(8'd251)); else n_pass++;
    n_done = 0;
    repeat (25) begin
      step();
      if (done === 1'b1) n_done++;
    end
    n_checks++; if (n_done !== 0 || busy !== 1'b0) $display("FAIL clear_no_done: got %0d pulses busy=%b want 0/0", n_done, busy); else n_pass++;
    clear = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL clear_idle: got busy=%b done=%b want 0/0", busy, done); else n_pass++;
    M = 8'd187; exp_q.push_back(model(8'd187)); start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL clear_start_wins: got busy=%b want 1", busy); else n_pass++;
    M = 8'd255;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(edges);
    n_checks++; if (done !== 1'b1 || edges + 2 !== 20) $display("FAIL clear_rerun_latency: got done=%b edges=%0d want 1/20", done, edges + 2); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++; if (Const !== e) $display("FAIL clear_rerun_const: got %0d want %0d", Const, e); else n_pass++;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_invalid();
    test_ena();
    test_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
